// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the sysid boot checker (master) and the sysid slave.
// The master drives address/read; the slave answers with waitrequest and readdata.
interface sysid_boot_checker_if;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (output address, read, input waitrequest, readdata);
  modport slave  (input address, read, output waitrequest, readdata);
endinterface

// File: rtl/sysid_boot_checker.sv
// Reads sysid words 0/1 after reset or start, checks them and releases the core reset on a match.
// Nominal run is 4 edges plus one per stall or latency cycle; waitrequest stalls are bounded by TIMEOUT_CYCLES.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1408812646,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  sysid_boot_checker_if.master avm,
  output logic [31:0]          id_value,
  output logic [31:0]          timestamp_value,
  output logic                 busy,
  output logic                 done,
  output logic                 ok,
  output logic                 id_mismatch,
  output logic                 ts_mismatch,
  output logic                 timeout,
  output logic                 core_reset_n
);

  typedef enum logic [2:0] {
    BOOT,
    RD_ID,
    LAT_ID,
    RD_TS,
    LAT_TS,
    CHECK,
    DONE
  } state_t;

  localparam int          LAT_M1   = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
  localparam int          TO_M1    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [1:0]  LAT_LAST = LAT_M1[1:0];
  localparam logic [15:0] TO_LAST  = TO_M1[15:0];

  state_t      state;
  state_t      state_nxt;
  logic [15:0] stall_cnt;
  logic [1:0]  lat_cnt;
  logic        cap_id;
  logic        cap_ts;
  logic        stall_inc;
  logic        lat_inc;
  logic        to_hit;
  logic        chk;
  logic        restart;
  logic        id_ne;
  logic        ts_ne;

  assign avm.read    = (state == RD_ID) || (state == RD_TS);
  assign avm.address = (state == RD_TS) || (state == LAT_TS);
  assign busy        = (state != BOOT) && (state != DONE);
  assign done        = (state == DONE);

  assign id_ne = (id_value != EXPECTED_ID);
  assign ts_ne = (timestamp_value != EXPECTED_TIMESTAMP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cap_id    = 1'b0;
    cap_ts    = 1'b0;
    stall_inc = 1'b0;
    lat_inc   = 1'b0;
    to_hit    = 1'b0;
    chk       = 1'b0;
    restart   = 1'b0;
    case (state)
      BOOT: state_nxt = RD_ID;
      RD_ID, RD_TS: begin
        if (avm.waitrequest) begin
          // The edge that would make the stall count reach the limit aborts the run.
          if (stall_cnt == TO_LAST) begin
            to_hit    = 1'b1;
            state_nxt = DONE;
          end else begin
            stall_inc = 1'b1;
          end
        end else if (READ_LATENCY == 0) begin
          cap_id    = (state == RD_ID);
          cap_ts    = (state == RD_TS);
          state_nxt = (state == RD_ID) ? RD_TS : CHECK;
        end else begin
          state_nxt = (state == RD_ID) ? LAT_ID : LAT_TS;
        end
      end
      LAT_ID, LAT_TS: begin
        if (lat_cnt == LAT_LAST) begin
          cap_id    = (state == LAT_ID);
          cap_ts    = (state == LAT_TS);
          state_nxt = (state == LAT_ID) ? RD_TS : CHECK;
        end else begin
          lat_inc = 1'b1;
        end
      end
      CHECK: begin
        chk       = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          restart   = 1'b1;
          state_nxt = RD_ID;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt       <= '0;
      lat_cnt         <= '0;
      id_value        <= '0;
      timestamp_value <= '0;
      ok              <= 1'b0;
      id_mismatch     <= 1'b0;
      ts_mismatch     <= 1'b0;
      timeout         <= 1'b0;
      core_reset_n    <= 1'b0;
    end else begin
      // Both counters restart whenever the state changes, i.e. on entry to RD_x / LAT_x.
      if (state_nxt != state) begin
        stall_cnt <= '0;
      end else if (stall_inc) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (state_nxt != state) begin
        lat_cnt <= '0;
      end else if (lat_inc) begin
        lat_cnt <= lat_cnt + 2'd1;
      end
      if (cap_id) begin
        id_value <= avm.readdata;
      end
      if (cap_ts) begin
        timestamp_value <= avm.readdata;
      end
      if (restart) begin
        ok          <= 1'b0;
        id_mismatch <= 1'b0;
        ts_mismatch <= 1'b0;
        timeout     <= 1'b0;
      end
      if (to_hit) begin
        ok          <= 1'b0;
        id_mismatch <= 1'b0;
        ts_mismatch <= 1'b0;
        timeout     <= 1'b1;
      end
      if (chk) begin
        id_mismatch <= id_ne;
        ts_mismatch <= ts_ne;
        ok          <= !(id_ne || ts_ne);
        timeout     <= 1'b0;
        // Sticky: a later failing re-run must not pull the running core back into reset.
        if (!(id_ne || ts_ne)) begin
          core_reset_n <= 1'b1;
        end
      end
    end
  end

  a_core_reset_sticky: assert property (@(posedge clock) disable iff (!reset_n)
    $past(core_reset_n) |-> core_reset_n);

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Scoreboard bench for sysid_boot_checker: three instances cover default, short-timeout and latency-2 builds.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1408812646;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] ts;
    logic        ok;
    logic        id_mm;
    logic        ts_mm;
    logic        to;
    logic        crn;
    logic        rd;
    logic [15:0] edges;
    logic [7:0]  reads;
  } res_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic wr_a = 1'b0, wr_b = 1'b0, wr_c = 1'b0;
  logic [31:0] w0_a = EXP_ID, w1_a = EXP_TS;
  logic [31:0] w0_b = EXP_ID, w1_b = EXP_TS;
  logic [31:0] w0_c = EXP_ID, w1_c = EXP_TS;

  logic [31:0] id_a, ts_a, id_b, ts_b, id_c, ts_c;
  logic busy_a, done_a, ok_a, idm_a, tsm_a, to_a, crn_a;
  logic busy_b, done_b, ok_b, idm_b, tsm_b, to_b, crn_b;
  logic busy_c, done_c, ok_c, idm_c, tsm_c, to_c, crn_c;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   rd_a = 0, rd_b = 0, rd_c = 0;
  res_t exp_q[$];

  logic c_acc1 = 1'b0, c_acc2 = 1'b0, c_a1 = 1'b0, c_a2 = 1'b0;

  always #5 clock = ~clock;

  sysid_boot_checker_if bus_a ();
  sysid_boot_checker_if bus_b ();
  sysid_boot_checker_if bus_c ();

  // Zero-latency sysid slaves.
  assign bus_a.waitrequest = wr_a;
  assign bus_a.readdata    = bus_a.address ? w1_a : w0_a;
  assign bus_b.waitrequest = wr_b;
  assign bus_b.readdata    = bus_b.address ? w1_b : w0_b;

  // Latency-2 slave: data is valid only in the cycle before the second edge after acceptance.
  always @(posedge clock) begin
    c_acc1 <= bus_c.read && !bus_c.waitrequest;
    c_a1   <= bus_c.address;
    c_acc2 <= c_acc1;
    c_a2   <= c_a1;
  end
  assign bus_c.waitrequest = wr_c;
  assign bus_c.readdata    = c_acc2 ? (c_a2 ? w1_c : w0_c) : 32'hDEAD_BEEF;

  always @(negedge clock) begin
    if (bus_a.read) rd_a++;
    if (bus_b.read) rd_b++;
    if (bus_c.read) rd_c++;
  end

  sysid_boot_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
                       .READ_LATENCY(0), .TIMEOUT_CYCLES(255)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .avm(bus_a),
    .id_value(id_a), .timestamp_value(ts_a), .busy(busy_a), .done(done_a), .ok(ok_a),
    .id_mismatch(idm_a), .ts_mismatch(tsm_a), .timeout(to_a), .core_reset_n(crn_a));

  sysid_boot_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
                       .READ_LATENCY(0), .TIMEOUT_CYCLES(8)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .avm(bus_b),
    .id_value(id_b), .timestamp_value(ts_b), .busy(busy_b), .done(done_b), .ok(ok_b),
    .id_mismatch(idm_b), .ts_mismatch(tsm_b), .timeout(to_b), .core_reset_n(crn_b));

  sysid_boot_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
                       .READ_LATENCY(2), .TIMEOUT_CYCLES(255)) dut_c (
    .clock(clock), .reset_n(reset_n), .start(start_c), .avm(bus_c),
    .id_value(id_c), .timestamp_value(ts_c), .busy(busy_c), .done(done_c), .ok(ok_c),
    .id_mismatch(idm_c), .ts_mismatch(tsm_c), .timeout(to_c), .core_reset_n(crn_c));

  function automatic res_t mk(input logic [31:0] id, input logic [31:0] ts, input logic okv,
                              input logic idm, input logic tsm, input logic tov, input logic crn,
                              input int edges, input int reads);
    res_t r;
    r       = '0;
    r.id    = id;
    r.ts    = ts;
    r.ok    = okv;
    r.id_mm = idm;
    r.ts_mm = tsm;
    r.to    = tov;
    r.crn   = crn;
    r.rd    = 1'b0;
    r.edges = 16'(edges);
    r.reads = 8'(reads);
    return r;
  endfunction

  function automatic res_t grab(input int sel, input int edges, input int reads);
    res_t r;
    r = '0;
    case (sel)
      0: begin
        r.id = id_a; r.ts = ts_a; r.ok = ok_a; r.id_mm = idm_a; r.ts_mm = tsm_a;
        r.to = to_a; r.crn = crn_a; r.rd = bus_a.read;
      end
      1: begin
        r.id = id_b; r.ts = ts_b; r.ok = ok_b; r.id_mm = idm_b; r.ts_mm = tsm_b;
        r.to = to_b; r.crn = crn_b; r.rd = bus_b.read;
      end
      default: begin
        r.id = id_c; r.ts = ts_c; r.ok = ok_c; r.id_mm = idm_c; r.ts_mm = tsm_c;
        r.to = to_c; r.crn = crn_c; r.rd = bus_c.read;
      end
    endcase
    r.edges = 16'(edges);
    r.reads = 8'(reads);
    return r;
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  // Counts edges until done is seen at #1 after an edge; 9999 marks an expired budget.
  task automatic wait_done(input int sel, input int max, output int edges);
    edges = 0;
    for (int i = 0; i < max; i++) begin
      @(posedge clock);
      #1;
      edges++;
      if (done_of(sel)) return;
    end
    edges = 9999;
  endtask

  task automatic reset_and_release();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if ({bus_a.read, bus_a.address, busy_a, done_a, ok_a, idm_a, tsm_a, to_a, crn_a} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl_a: got %b want 000000000",
               {bus_a.read, bus_a.address, busy_a, done_a, ok_a, idm_a, tsm_a, to_a, crn_a});
    end
    n_cmp++;
    if ({id_a, ts_a} !== 64'b0) begin
      n_bad++;
      $display("FAIL reset_words_a: got %h %h want 0 0", id_a, ts_a);
    end
    n_cmp++;
    if ({busy_b, done_b, crn_b, bus_b.read, busy_c, done_c, crn_c, bus_c.read} !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_bc: got %b want 00000000",
               {busy_b, done_b, crn_b, bus_b.read, busy_c, done_c, crn_c, bus_c.read});
    end
  endtask

  task automatic test_nominal();
    int   e, e2, r0;
    res_t got, want;
    w0_a = EXP_ID; w1_a = EXP_TS; wr_a = 1'b0;
    exp_q.push_back(mk(EXP_ID, EXP_TS, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 2));
    start_a = 1'b1;
    r0 = rd_a;
    reset_and_release();
    @(posedge clock);
    #1;
    start_a = 1'b0;
    e = 1;
    n_cmp++;
    if ({busy_a, bus_a.read, bus_a.address} !== 3'b110) begin
      n_bad++;
      $display("FAIL nominal_e1: got %b want 110", {busy_a, bus_a.read, bus_a.address});
    end
    wait_done(0, 20, e2);
    e += e2;
    got  = grab(0, e, rd_a - r0);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL nominal: got %p want %p", got, want);
    end
  endtask

  task automatic test_mismatch();
    int   e, e2, r0;
    res_t got, want;
    w1_a = EXP_TS + 32'd1;
    exp_q.push_back(mk(EXP_ID, EXP_TS + 32'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4, 2));
    r0 = rd_a;
    reset_and_release();
    wait_done(0, 20, e);
    got  = grab(0, e, rd_a - r0);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL ts_mismatch: got %p want %p", got, want);
    end

    // Fixed image, re-run by start: flags clear on the first edge, core released at edge 4.
    for (int pass = 0; pass < 2; pass++) begin
      w1_a = (pass == 0) ? EXP_TS : EXP_TS + 32'd1;
      if (pass == 0)
        exp_q.push_back(mk(EXP_ID, EXP_TS, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 2));
      else
        exp_q.push_back(mk(EXP_ID, EXP_TS + 32'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4, 2));
      @(negedge clock);
      start_a = 1'b1;
      r0 = rd_a;
      @(posedge clock);
      #1;
      start_a = 1'b0;
      e = 1;
      n_cmp++;
      if ({done_a, ok_a, idm_a, tsm_a, to_a, busy_a} !== 6'b000001) begin
        n_bad++;
        $display("FAIL restart_clear[%0d]: got %b want 000001", pass,
                 {done_a, ok_a, idm_a, tsm_a, to_a, busy_a});
      end
      wait_done(0, 20, e2);
      e += e2;
      got  = grab(0, e, rd_a - r0);
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL rerun[%0d]: got %p want %p", pass, got, want);
      end
    end
    w1_a = EXP_TS;
  endtask

  task automatic test_stall();
    int   e, e2, r0;
    res_t got, want;
    w1_a = EXP_TS;
    wr_a = 1'b1;
    exp_q.push_back(mk(EXP_ID, EXP_TS, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 14, 12));
    r0 = rd_a;
    reset_and_release();
    e = 0;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clock);
      #1;
      e++;
      n_cmp++;
      if (!(bus_a.read === 1'b1 && bus_a.address === 1'b0)) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got read=%b addr=%b want read=1 addr=0", i,
                 bus_a.read, bus_a.address);
      end
    end
    wr_a = 1'b0;
    wait_done(0, 20, e2);
    e += e2;
    got  = grab(0, e, rd_a - r0);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL stall: got %p want %p", got, want);
    end
  endtask

  task automatic test_timeout();
    int   e, r0;
    res_t got, want;
    wr_b = 1'b1;
    exp_q.push_back(mk(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9, 8));
    r0 = rd_b;
    reset_and_release();
    wait_done(1, 30, e);
    got  = grab(1, e, rd_b - r0);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL timeout: got %p want %p", got, want);
    end
    wr_b = 1'b0;
  endtask

  task automatic test_latency();
    int   e, e2, r0, r1;
    res_t got, want;
    w0_c = EXP_ID; w1_c = EXP_TS; wr_c = 1'b0;
    exp_q.push_back(mk(EXP_ID, EXP_TS, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8, 2));
    r0 = rd_c;
    reset_and_release();
    @(posedge clock); #1;
    @(posedge clock); #1;
    start_c = 1'b1;
    @(posedge clock); #1;
    start_c = 1'b0;
    e = 3;
    n_cmp++;
    if (busy_c !== 1'b1) begin
      n_bad++;
      $display("FAIL latency_busy: got %b want 1", busy_c);
    end
    wait_done(2, 20, e2);
    e += e2;
    got  = grab(2, e, rd_c - r0);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL latency: got %p want %p", got, want);
    end
    r1 = rd_c;
    repeat (4) @(posedge clock);
    #1;
    n_cmp++;
    if ({done_c, 8'(rd_c - r1)} !== {1'b1, 8'd0}) begin
      n_bad++;
      $display("FAIL latency_idle: got done=%b extra_reads=%0d want done=1 extra_reads=0",
               done_c, rd_c - r1);
    end
  endtask

  task automatic test_reset_mid();
    int   e, r0;
    res_t got, want;
    w1_a = EXP_TS;
    exp_q.push_back(mk(EXP_ID, EXP_TS, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 2));
    @(negedge clock);
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if ({bus_a.read, bus_a.address, crn_a} !== 3'b111) begin
      n_bad++;
      $display("FAIL mid_rd_ts: got %b want 111", {bus_a.read, bus_a.address, crn_a});
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_a.read, bus_a.address, busy_a, done_a, ok_a, idm_a, tsm_a, to_a, crn_a} !== 9'b0) begin
      n_bad++;
      $display("FAIL mid_async: got %b want 000000000",
               {bus_a.read, bus_a.address, busy_a, done_a, ok_a, idm_a, tsm_a, to_a, crn_a});
    end
    @(negedge clock);
    @(negedge clock);
    r0 = rd_a;
    reset_n = 1'b1;
    wait_done(0, 20, e);
    got  = grab(0, e, rd_a - r0);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL mid_rerun: got %p want %p", got, want);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mismatch();
    test_stall();
    test_timeout();
    test_latency();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
